count_game_ctrl: RTL and testbench
==================================

# count_game_ctrl

Upstream control stage of the count game: debounces three raw pushbuttons, runs the game state machine, and drives the countdown counter's `num`, `cst` and `dzst` inputs. It consumes the counter's `over` flag to detect the end of a run. It sits between the board keys and the counter and runs on the same 1 kHz game clock, where 1000 cycles equal 1 s.

## Interface
- `DEB_CYCLES`, default 20: stable-level cycles required before a key change is accepted (20 ms at 1 kHz).
- `NUM_INIT`, default 3'd5: countdown start value after reset; legal range 1..7.

- `clk` in 1: game clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high; forces every register to its reset value.
- `key_sel` in 1: raw select key, active-high, asynchronous to `clk`.
- `key_start` in 1: raw start key, active-high, asynchronous.
- `key_stop` in 1: raw stop/abort key, active-high, asynchronous.
- `over` in 1: counter finished flag; a registered level.
- `num` out 3: countdown start value presented to the counter.
- `cst` out 1: counter load/run control.
  - 0: counter holds `num` loaded and clears `over`.
  - 1: counter counts down.
- `dzst` out 1: dot-matrix display enable.
- `led_done` out 1: high while the game is in DONE.

## Operation
- Each key passes through its own debouncer:
  - 2-FF synchroniser.
  - Stability counter, reset whenever the synced level equals the accepted level.
  - Accepted level updates after `DEB_CYCLES` consecutive differing cycles.
  - Emits a registered 1-cycle press pulse on an accepted 0->1 change only. Releases produce no pulse.
- Holding a key produces exactly one pulse. Glitches shorter than `DEB_CYCLES` produce none.
- The FSM acts on at most one pulse per cycle. Priority when pulses coincide: stop > start > sel.
- States: IDLE, SETUP, RUN, DONE; encoding is 2-bit.
  - IDLE: `cst`=0, `dzst`=0. start -> SETUP. sel and stop are ignored.
  - SETUP: `cst`=0, `dzst`=1.
    - sel: `num` <= `num`+1, wrapping 7 -> 1. `num` is never 0.
    - start -> RUN.
    - stop -> IDLE.
  - RUN: `cst`=1, `dzst`=1.
    - `over`=1 -> DONE.
    - stop -> SETUP; `cst` drops, so the counter reloads `num`.
    - sel and start are ignored.
    - If stop and `over` are both seen in the same cycle, stop wins.
  - DONE: `cst`=1 (counter holds 0, `over` stays 1), `dzst`=1, `led_done`=1.
    - start -> SETUP.
    - stop -> IDLE.
    - sel is ignored.
- `num` changes only in SETUP. It keeps its value across RUN, DONE and IDLE until reset.
- `over` is ignored in every state except RUN.
- Reset values: state=IDLE, `num`=`NUM_INIT`, `cst`=0, `dzst`=0, `led_done`=0. Debouncer accepted levels, counters and pulses are all 0.
- Reset mid-run: all outputs revert immediately (asynchronous). `cst`=0 forces the counter to reload.

## Timing
- Number the edges so that a raw key going high before edge 1 gives:
  - s1=1 after edge 1.
  - s2=1 after edge 2.
  - Accepted level and pulse set at edge 2+`DEB_CYCLES`.
  - Pulse high for exactly one cycle.
- The FSM state and all outputs update at edge 3+`DEB_CYCLES`. With the default, that is 23 cycles from press to output change.
- `over` -> DONE: state and `led_done` update at the first edge where `over`=1 is sampled in RUN, giving 1-cycle latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `count_game_pkg`:
  - State encoding constants `ST_IDLE`=0, `ST_SETUP`=1, `ST_RUN`=2, `ST_DONE`=3.
  - `NUM_W`=3.
  - `NUM_MIN`=1, `NUM_MAX`=7.
- Sub-module `key_debounce`, parameterised by `DEB_CYCLES`, instantiated three times. Ports: `clk`, `rst`, `key_raw`, `key_level`, `key_pulse`.
- Top level holds the FSM and the `num` register.

## Test plan
Run all scenarios with `DEB_CYCLES`=4.

- Reset, then idle 20 cycles -> state IDLE, `num`=5, `cst`=0, `dzst`=0, `led_done`=0.
- start held 10 cycles -> `dzst` rises at edge 7 after the press (3+`DEB_CYCLES`), exactly one transition, state SETUP.
- In SETUP, 4 clean sel presses -> `num` goes 6, 7, 1, 2. A 2-cycle sel glitch -> `num` unchanged.
- In SETUP with `num`=2: start, then drive `over`=1 from 100 cycles later -> `cst` is 1 throughout RUN. The edge after `over`=1 is sampled: DONE, `led_done`=1, `cst` still 1.
- In RUN: stop pulse and `over`=1 in the same cycle -> SETUP, `cst`=0, `led_done`=0. Separately, start and sel pulses together in SETUP -> RUN with `num` unchanged.
- Assert `rst` for 1 cycle mid-RUN -> all outputs return to reset values without waiting for a clock edge; `num`=5.

Source files
------------

// File: rtl/count_game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_game_pkg
// Brief   : Shared state encoding, num bounds and num step helper for the
//           count game control stage.
// Revision: 1.0
// ============================================================================
package count_game_pkg;

   localparam int NUM_W = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SETUP = 2'd1;
   localparam state_t ST_RUN   = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam logic [NUM_W-1:0] NUM_MIN = 3'd1;
   localparam logic [NUM_W-1:0] NUM_MAX = 3'd7;

   // Step num upward, skipping 0 so the counter always has a real start value.
   function automatic logic [NUM_W-1:0] num_incr(input logic [NUM_W-1:0] n);
      return (n == NUM_MAX) ? NUM_MIN : n + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/count_game_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Brief   : 2-FF synchroniser plus stability counter; emits one registered
//           pulse per accepted press.
// Revision: 1.0
// ============================================================================
module key_debounce #(
   parameter int DEB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_pulse
);

   localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

   logic               r_s1;
   logic               r_s2;
   logic               r_level;
   logic               r_pulse;
   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= key_raw;
         r_s2    <= r_s1;
         r_pulse <= 1'b0;
         if (r_s2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_LAST) begin
            // Only rising acceptances pulse; releases just update the level.
            r_cnt   <= '0;
            r_level <= r_s2;
            r_pulse <= r_s2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign key_level = r_level;
   assign key_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/count_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : count_game_ctrl
// Brief   : Debounces the three game keys and runs the IDLE/SETUP/RUN/DONE
//           state machine driving the countdown counter.
// Revision: 1.0
// ============================================================================
module count_game_ctrl
   import count_game_pkg::*;
#(
   parameter int               DEB_CYCLES = 20,
   parameter logic [NUM_W-1:0] NUM_INIT   = 3'd5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_sel,
   input  logic             key_start,
   input  logic             key_stop,
   input  logic             over,
   output logic [NUM_W-1:0] num,
   output logic             cst,
   output logic             dzst,
   output logic             led_done
);

   logic [2:0] w_level;
   logic [2:0] w_pulse;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_sel),
      .key_level (w_level[0]),
      .key_pulse (w_pulse[0])
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_start),
      .key_level (w_level[1]),
      .key_pulse (w_pulse[1])
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_stop),
      .key_level (w_level[2]),
      .key_pulse (w_pulse[2])
   );

   // One event per cycle: stop beats start beats sel.
   logic w_stop;
   logic w_start;
   logic w_sel;

   assign w_stop  = w_pulse[2] & w_level[2];
   assign w_start = w_pulse[1] & w_level[1] & ~w_stop;
   assign w_sel   = w_pulse[0] & w_level[0] & ~w_stop & ~w_start;

   state_t           r_state;
   state_t           w_state_next;
   logic [NUM_W-1:0] r_num;
   logic [NUM_W-1:0] w_num_next;
   logic             r_cst;
   logic             r_dzst;
   logic             r_led_done;
   logic             w_cst_next;
   logic             w_dzst_next;
   logic             w_led_done_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_num      <= NUM_INIT;
         r_cst      <= 1'b0;
         r_dzst     <= 1'b0;
         r_led_done <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_num      <= w_num_next;
         r_cst      <= w_cst_next;
         r_dzst     <= w_dzst_next;
         r_led_done <= w_led_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_num_next   = r_num;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_next = ST_SETUP;
         end
         ST_SETUP: begin
            if (w_stop)       w_state_next = ST_IDLE;
            else if (w_start) w_state_next = ST_RUN;
            else if (w_sel)   w_num_next   = num_incr(r_num);
         end
         ST_RUN: begin
            if (w_stop)    w_state_next = ST_SETUP;
            else if (over) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (w_stop)       w_state_next = ST_IDLE;
            else if (w_start) w_state_next = ST_SETUP;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      w_cst_next      = (w_state_next == ST_RUN) || (w_state_next == ST_DONE);
      w_dzst_next     = (w_state_next != ST_IDLE);
      w_led_done_next = (w_state_next == ST_DONE);
   end

   assign num      = r_num;
   assign cst      = r_cst;
   assign dzst     = r_dzst;
   assign led_done = r_led_done;

endmodule
`default_nettype wire

// File: tb/tb_count_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_game_ctrl
// Brief   : Randomised key stimulus against an event-level game model; a
//           monitor pairs every output change with the next queued expectation.
// Revision: 1.0
// ============================================================================
module tb_count_game_ctrl;

   localparam int DEB = 4;
   localparam int M_IDLE = 0, M_SETUP = 1, M_RUN = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_sel = 1'b0;
   logic       key_start = 1'b0;
   logic       key_stop = 1'b0;
   logic       over = 1'b0;
   logic [2:0] num;
   logic       cst;
   logic       dzst;
   logic       led_done;

   count_game_ctrl #(.DEB_CYCLES(DEB), .NUM_INIT(3'd5)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_sel  (key_sel),
      .key_start(key_start),
      .key_stop (key_stop),
      .over     (over),
      .num      (num),
      .cst      (cst),
      .dzst     (dzst),
      .led_done (led_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int num;
      int cst;
      int dzst;
      int led;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   int   m_state;
   int   m_num;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: any change on the outputs consumes the oldest expectation.
   logic [5:0] cur;
   logic [5:0] prev;
   exp_t       e;
   always @(negedge clk) begin
      cur = {num, cst, dzst, led_done};
      if (!mon_en) begin
         prev = cur;
      end else begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_event_cycle", cyc, e.cyc);
         end
         if (cur !== prev) begin
            if (q.size() == 0) begin
               chk("unexpected_change", {26'd0, cur}, {26'd0, prev});
            end else begin
               e = q.pop_front();
               chk("event_cycle", cyc, e.cyc);
               chk("event_num", num, e.num);
               chk("event_cst", cst, e.cst);
               chk("event_dzst", dzst, e.dzst);
               chk("event_led_done", led_done, e.led);
            end
            prev = cur;
         end
      end
   end

   function automatic int st_cst(input int s);
      return (s == M_RUN || s == M_DONE) ? 1 : 0;
   endfunction

   task automatic push_if_changed(input int when, input int os, input int on);
      exp_t x;
      if (os != m_state || on != m_num) begin
         x.cyc  = when;
         x.num  = m_num;
         x.cst  = st_cst(m_state);
         x.dzst = (m_state != M_IDLE) ? 1 : 0;
         x.led  = (m_state == M_DONE) ? 1 : 0;
         q.push_back(x);
      end
   endtask

   // mask = {stop, start, sel}; only the highest-priority key is acted upon.
   task automatic model_keys(input logic [2:0] mask, input int when);
      int os = m_state;
      int on = m_num;
      if (mask[2]) begin
         if (m_state == M_SETUP || m_state == M_DONE) m_state = M_IDLE;
         else if (m_state == M_RUN) m_state = M_SETUP;
      end else if (mask[1]) begin
         if (m_state == M_IDLE || m_state == M_DONE) m_state = M_SETUP;
         else if (m_state == M_SETUP) m_state = M_RUN;
      end else if (mask[0]) begin
         if (m_state == M_SETUP) m_num = (m_num == 7) ? 1 : m_num + 1;
      end
      push_if_changed(when, os, on);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press_hold(input logic [2:0] mask, input int hold);
      model_keys(mask, cyc + 3 + DEB);
      {key_stop, key_start, key_sel} = mask;
      tick(hold);
      {key_stop, key_start, key_sel} = 3'b000;
      tick(DEB + 8);
   endtask

   task automatic press(input logic [2:0] mask);
      press_hold(mask, $urandom_range(DEB + 5, DEB));
   endtask

   task automatic glitch(input int len);
      key_sel = 1'b1;
      tick(len);
      key_sel = 1'b0;
      tick(DEB + 8);
   endtask

   task automatic over_pulse(input int len);
      int os = m_state;
      if (m_state == M_RUN) m_state = M_DONE;
      push_if_changed(cyc + 1, os, m_num);
      over = 1'b1;
      tick(len);
      over = 1'b0;
      tick(3);
   endtask

   // Stop pulse and over=1 reach the FSM on the same edge while in RUN.
   task automatic stop_over();
      model_keys(3'b100, cyc + 3 + DEB);
      key_stop = 1'b1;
      tick(2 + DEB);
      over = 1'b1;
      tick(2);
      key_stop = 1'b0;
      over = 1'b0;
      tick(DEB + 8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      m_state = M_IDLE;
      m_num   = 5;
      tick(3);
      rst = 1'b0;
      tick(20);
      chk("reset_num", num, 5);
      chk("reset_cst", cst, 0);
      chk("reset_dzst", dzst, 0);
      chk("reset_led_done", led_done, 0);
      mon_en = 1'b1;

      press_hold(3'b010, 10);
      chk("setup_dzst", dzst, 1);
      repeat (4) press(3'b001);
      chk("num_after_4_sel", num, 2);
      glitch(2);
      glitch($urandom_range(DEB - 1, 1));
      chk("num_after_glitch", num, 2);

      press(3'b010);
      tick(100);
      chk("run_cst", cst, 1);
      over_pulse(3);
      chk("done_led", led_done, 1);
      chk("done_cst", cst, 1);

      press(3'b010);
      press(3'b010);
      stop_over();
      chk("stop_over_cst", cst, 0);
      chk("stop_over_led", led_done, 0);
      press(3'b011);
      chk("start_sel_num", num, m_num);
      chk("start_sel_cst", cst, 1);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(9, 0))
            0, 1, 2: press(3'b001);
            3, 4:    press(3'b010);
            5:       press(3'b100);
            6:       over_pulse($urandom_range(3, 1));
            7:       glitch($urandom_range(DEB - 1, 1));
            8:       press(3'($urandom_range(7, 1)));
            default: if (m_state == M_RUN) stop_over(); else press(3'b001);
         endcase
      end

      repeat (3) if (m_state != M_RUN) press(3'b010);
      chk("pre_reset_state_run", cst, 1);
      chk("pending_before_reset", q.size(), 0);

      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_num", num, 5);
      chk("async_rst_cst", cst, 0);
      chk("async_rst_dzst", dzst, 0);
      chk("async_rst_led", led_done, 0);
      tick(1);
      rst = 1'b0;
      q.delete();
      m_state = M_IDLE;
      m_num   = 5;
      tick(2);
      mon_en = 1'b1;
      press(3'b010);
      press(3'b001);
      chk("post_reset_num", num, 6);
      tick(5);
      chk("pending_at_end", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
